my_nios2_sysid_checker: RTL and testbench
=========================================

MY_NIOS2_SYSID_CHECKER -- requirements
Module: my_nios2_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0: expected system ID word (sysid address 0).
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1417976097: expected timestamp word (sysid address 1).
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to run an ID check.
REQ-006 SHALL have port host_read, input, 1: host read request to the sysid slave.
REQ-007 SHALL have port host_address, input, 1: host word select.
REQ-008 SHALL have port host_readdata, output, 32: data returned to the host.
REQ-009 SHALL have port host_waitrequest, output, 1: host must hold its request while high.
REQ-010 SHALL have port sysid_address, output, 1: address driven to the sysid slave.
REQ-011 SHALL have port sysid_readdata, input, 32: combinational sysid read data, valid in the same cycle as sysid_address.
REQ-012 SHALL have port busy, output, 1: check in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at check completion.
REQ-014 SHALL have port id_ok, output, 1: last captured ID equals EXPECTED_ID.
REQ-015 SHALL have port ts_ok, output, 1: last captured timestamp equals EXPECTED_TS.
REQ-016 SHALL have port pass, output, 1: id_ok AND ts_ok of the last check.
REQ-017 SHALL have port captured_id, output, 32: ID word from the last check.
REQ-018 SHALL have port captured_ts, output, 32: timestamp word from the last check.
REQ-019 SHALL have port error_count, output, 8: count of failed checks, saturating at 255.

Function
REQ-020 SHALL implement states IDLE, RD_ID, RD_TS and CMP; busy SHALL be high in every state except IDLE.
REQ-021 In IDLE with start=1, the next state SHALL be RD_ID; start SHALL be ignored in every other state.
REQ-022 RD_ID SHALL drive sysid_address=0, load captured_id from sysid_readdata at the cycle end, and go to RD_TS.
REQ-023 RD_TS SHALL drive sysid_address=1, load captured_ts at the cycle end, and go to CMP.
REQ-024 CMP SHALL register id_ok, ts_ok and pass, set done=1 for exactly the next cycle, and go to IDLE.
REQ-025 Latency SHALL be fixed: start sampled in cycle N gives done=1 in cycle N+4.
REQ-026 On a failed check (pass=0), error_count SHALL increment by 1 and SHALL hold at 255 once reached.
REQ-027 The host SHALL be granted only in IDLE with start=0 and no pending autostart; in that case host_waitrequest=0, sysid_address=host_address and host_readdata=sysid_readdata, all combinational (zero wait states).
REQ-028 Otherwise host_waitrequest SHALL equal host_read, and host_readdata SHALL be 0.
REQ-029 When start and host_read are both high in IDLE, start SHALL win and the host SHALL wait until the cycle after CMP.
REQ-030 When the checker does not own the bus and no host read is granted, sysid_address SHALL be 0.

Reset
REQ-031 reset SHALL force IDLE, set busy, done, id_ok, ts_ok and pass to 0, clear captured_id, captured_ts and error_count to 0, and set host_waitrequest to 0.
REQ-032 reset asserted mid-check SHALL abort the check with no done pulse and no error_count update.

Configuration
REQ-033 With macro MY_NIOS2_SYSID_AUTOSTART_EN defined, the first cycle after reset deasserts SHALL act as start=1, and the host SHALL wait until that check completes.
REQ-034 Without MY_NIOS2_SYSID_AUTOSTART_EN, a check SHALL run only on an explicit start.

Verification
REQ-035 Sysid model returns 0 / 1417976097; pulse start in cycle 0 -> busy high in cycles 1-3; done=1 in cycle 4; pass=1; error_count=0.
REQ-036 Model timestamp 32'h0000_0001, run two checks -> ts_ok=0, id_ok=1, pass=0, error_count=2.
REQ-037 Checker idle, host_read=1, host_address=1 -> host_waitrequest=0 and host_readdata=1417976097 in the same cycle.
REQ-038 start and host_read=1 in the same cycle -> host_waitrequest=1 for 4 cycles, then the host is granted.
REQ-039 reset asserted in RD_TS -> next cycle IDLE, no done pulse, error_count=0, captured_ts=0.
REQ-040 With MY_NIOS2_SYSID_AUTOSTART_EN defined, release reset with start held 0 -> done=1 four cycles after reset release.

Source files
------------

// File: rtl/my_nios2_sysid_checker.sv
// my_nios2_sysid_checker
//   Reads the sysid slave's ID word (address 0) and build timestamp word
//   (address 1), compares them against EXPECTED_ID / EXPECTED_TS and
//   reports the result. Between checks the sysid slave is passed straight
//   through to a host port with zero wait states.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle check request (honoured only in IDLE)
//   host_read/address     : host request to the sysid slave
//   host_readdata         : sysid data for the host (0 when not granted)
//   host_waitrequest      : host must hold its request while high
//   sysid_address         : address to the sysid slave
//   sysid_readdata        : combinational sysid read data
//   busy, done            : check in progress / one-cycle completion pulse
//   id_ok, ts_ok, pass    : result of the last completed check
//   captured_id/_ts       : words read by the last check
//   error_count           : failed checks, saturating at 255
//
// Configuration
//   MY_NIOS2_SYSID_AUTOSTART_EN : when defined, the first cycle after reset
//   deasserts behaves as start=1 and the host is held off until that check
//   completes.
module my_nios2_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1417976097
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        host_read,
    input  logic        host_address,
    output logic [31:0] host_readdata,
    output logic        host_waitrequest,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  error_count
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

    state_t state, state_nxt;
    logic   auto_pending;
    logic   grant;
    logic   id_match, ts_match;

`ifdef MY_NIOS2_SYSID_AUTOSTART_EN
    // Set throughout reset, so it is high exactly in the first cycle after
    // reset is released and then clears.
    always_ff @(posedge clock) begin
        if (reset) auto_pending <= 1'b1;
        else       auto_pending <= 1'b0;
    end
`else
    assign auto_pending = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start || auto_pending) state_nxt = RD_ID;
            RD_ID:   state_nxt = RD_TS;
            RD_TS:   state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign id_match = (captured_id == EXPECTED_ID);
    assign ts_match = (captured_ts == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            captured_id <= 32'd0;
            captured_ts <= 32'd0;
            error_count <= 8'd0;
        end else begin
            done <= (state == CMP);
            if (state == RD_ID) captured_id <= sysid_readdata;
            if (state == RD_TS) captured_ts <= sysid_readdata;
            if (state == CMP) begin
                id_ok <= id_match;
                ts_ok <= ts_match;
                pass  <= id_match && ts_match;
                if (!(id_match && ts_match) && error_count != 8'hFF)
                    error_count <= error_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

    // A start (explicit or automatic) in IDLE beats a simultaneous host read.
    assign grant = (state == IDLE) && !start && !auto_pending && !reset;

    assign host_waitrequest = !reset && !grant && host_read;
    assign host_readdata    = grant ? sysid_readdata : 32'd0;

    always_comb begin
        sysid_address = 1'b0;
        case (state)
            RD_ID:   sysid_address = 1'b0;
            RD_TS:   sysid_address = 1'b1;
            default: sysid_address = grant && host_read && host_address;
        endcase
    end

endmodule

// File: tb/tb_my_nios2_sysid_checker.sv
// Directed bench for my_nios2_sysid_checker: a per-cycle vector table for
// the start/host arbitration sequence, plus hand-written sequences for
// failing checks, mid-check reset, error saturation and autostart.
module tb_my_nios2_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1417976097;

    logic        clock = 1'b0;
    logic        reset, start, host_read, host_address;
    logic [31:0] host_readdata, sysid_readdata, captured_id, captured_ts;
    logic        host_waitrequest, sysid_address, busy, done, id_ok, ts_ok, pass;
    logic [7:0]  error_count;

    logic [31:0] model_id, model_ts;
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    // Combinational sysid slave model
    assign sysid_readdata = sysid_address ? model_ts : model_id;

    my_nios2_sysid_checker dut (
        .clock(clock), .reset(reset), .start(start),
        .host_read(host_read), .host_address(host_address),
        .host_readdata(host_readdata), .host_waitrequest(host_waitrequest),
        .sysid_address(sysid_address), .sysid_readdata(sysid_readdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass),
        .captured_id(captured_id), .captured_ts(captured_ts),
        .error_count(error_count)
    );

    typedef struct {
        logic        start, hr, ha;
        logic        e_busy, e_done, e_wait, e_addr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("idle_timeout", 1, 0);
    endtask

    // Pulse start, then demand done exactly four cycles later.
    task automatic run_check(input string name);
        int lat = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (done === 1'b1) begin lat = k; break; end
            tick();
        end
        check({name, "_latency"}, lat, 4);
        tick();
    endtask

    initial begin
        // start, hr, ha | busy, done, wait, addr, rdata
        vecs[0] = '{1, 1, 1, 0, 0, 1, 0, 32'd0};     // start wins over host read
        vecs[1] = '{0, 1, 1, 1, 0, 1, 0, 32'd0};     // RD_ID
        vecs[2] = '{1, 1, 1, 1, 0, 1, 1, 32'd0};     // RD_TS, start ignored
        vecs[3] = '{0, 1, 1, 1, 0, 1, 0, 32'd0};     // CMP
        vecs[4] = '{0, 1, 1, 0, 1, 0, 1, TS_GOOD};   // done, host granted
        vecs[5] = '{0, 1, 0, 0, 0, 0, 0, 32'h1234};  // host reads ID word
        vecs[6] = '{0, 0, 1, 0, 0, 0, 0, 32'h1234};  // no read: address 0
        vecs[7] = '{0, 1, 1, 0, 0, 0, 1, TS_GOOD};   // idle host read of TS

        model_id = 32'd0;
        model_ts = TS_GOOD;
        reset = 1'b1; start = 1'b0; host_read = 1'b0; host_address = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", {id_ok, ts_ok, pass}, 0);
        check("rst_capid", captured_id, 0);
        check("rst_capts", captured_ts, 0);
        check("rst_errcnt", error_count, 0);
        host_read = 1'b1; #1;
        check("rst_wait", host_waitrequest, 0);
        host_read = 1'b0;

        reset = 1'b0;
`ifdef MY_NIOS2_SYSID_AUTOSTART_EN
        begin
            int lat = -1;
            host_read = 1'b1; #1;
            check("auto_hostwait", host_waitrequest, 1);
            host_read = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                if (done === 1'b1) begin lat = k; break; end
                tick();
            end
            check("auto_latency", lat, 4);
            check("auto_pass", pass, 1);
            tick();
        end
`else
        for (int k = 0; k < 5; k++) begin
            check("noauto_busy", busy, 0);
            tick();
        end
`endif

        // Table-driven arbitration and pass-through (REQ-035/037/038)
        model_id = 32'd0;
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; host_read = vecs[i].hr; host_address = vecs[i].ha;
            if (i == 5) model_id = 32'h1234;
            #1;
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check($sformatf("v%0d_wait", i), host_waitrequest, vecs[i].e_wait);
            check($sformatf("v%0d_addr", i), sysid_address, vecs[i].e_addr);
            check($sformatf("v%0d_rdata", i), host_readdata, vecs[i].e_rdata);
            tick();
        end
        start = 1'b0; host_read = 1'b0; host_address = 1'b0;
        model_id = 32'd0;
        check("good_pass", {id_ok, ts_ok, pass}, 3'b111);
        check("good_capts", captured_ts, TS_GOOD);
        check("good_errcnt", error_count, 0);

        // Two failing checks on a bad timestamp
        model_ts = 32'h0000_0001;
        run_check("bad1");
        run_check("bad2");
        check("bad_idok", id_ok, 1);
        check("bad_tsok", ts_ok, 0);
        check("bad_pass", pass, 0);
        check("bad_capts", captured_ts, 32'h1);
        check("bad_errcnt", error_count, 2);

        // Reset during RD_TS aborts the check
        start = 1'b1; tick(); start = 1'b0;   // now RD_ID
        tick();                                 // now RD_TS
        check("abort_in_rdts", sysid_address, 1);
        reset = 1'b1; tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_errcnt", error_count, 0);
        check("abort_capts", captured_ts, 0);
        reset = 1'b0;
`ifdef MY_NIOS2_SYSID_AUTOSTART_EN
        wait_idle();
        tick();
`else
        for (int k = 0; k < 5; k++) begin
            check("abort_nodone", done, 0);
            tick();
        end
`endif

        // Saturation at 255
        model_ts = 32'h0000_0001;
        for (int i = 0; i < 256; i++) begin
            start = 1'b1; tick(); start = 1'b0;
            wait_idle();
            tick();
        end
        check("sat_errcnt", error_count, 8'd255);
        model_ts = TS_GOOD;
        run_check("recover");
        check("recover_pass", pass, 1);
        check("recover_errcnt", error_count, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
